// File: rtl/mc_ctrl_unit.sv
// Multi-cycle MIPS control FSM: sequences PC, IR, register file, ALU and the
// shared memory port; every strobe and select is a decode of the current state.
module mc_ctrl_unit #(
   parameter int ST_W = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            mem_ready,
   input  logic [5:0]      opcode,
   input  logic [5:0]      funct,
   input  logic            zero,
   output logic            pc_ce,
   output logic            ior_d,
   output logic            mem_rd,
   output logic            mem_wr,
   output logic            ir_we,
   output logic            reg_we,
   output logic [1:0]      reg_dst,
   output logic [1:0]      mem_to_reg,
   output logic            alu_src_a,
   output logic [1:0]      alu_src_b,
   output logic            imm_zext,
   output logic [2:0]      alu_ctrl,
   output logic [1:0]      pc_src,
   output logic [ST_W-1:0] state
);

   localparam logic [ST_W-1:0] S_IF  = ST_W'(0);
   localparam logic [ST_W-1:0] S_ID  = ST_W'(1);
   localparam logic [ST_W-1:0] S_MA  = ST_W'(2);
   localparam logic [ST_W-1:0] S_MRD = ST_W'(3);
   localparam logic [ST_W-1:0] S_LWB = ST_W'(4);
   localparam logic [ST_W-1:0] S_MWR = ST_W'(5);
   localparam logic [ST_W-1:0] S_EXR = ST_W'(6);
   localparam logic [ST_W-1:0] S_RWB = ST_W'(7);
   localparam logic [ST_W-1:0] S_BR  = ST_W'(8);
   localparam logic [ST_W-1:0] S_J   = ST_W'(9);
   localparam logic [ST_W-1:0] S_JAL = ST_W'(10);
   localparam logic [ST_W-1:0] S_EXI = ST_W'(11);
   localparam logic [ST_W-1:0] S_IWB = ST_W'(12);
   localparam logic [ST_W-1:0] S_JR  = ST_W'(13);
   localparam logic [ST_W-1:0] S_ILL = ST_W'(14);

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_JAL  = 6'b000011;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_SLTI = 6'b001010;
   localparam logic [5:0] FN_JR   = 6'b001000;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;
   localparam logic [2:0] ALU_NOR = 3'b100;

   logic [ST_W-1:0] state_q, state_d;
   logic            r_known;
   logic [2:0]      r_alu;
   logic [2:0]      i_alu;
   logic            pc_ce_raw, mem_rd_raw, mem_wr_raw, ir_we_raw, reg_we_raw;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IF;
      else     state_q <= state_d;
   end

   // R-type funct table; r_known separates real ALU ops from ILL
   always_comb begin
      r_known = 1'b1;
      r_alu   = ALU_ADD;
      case (funct)
         6'b100000: r_alu = ALU_ADD;
         6'b100010: r_alu = ALU_SUB;
         6'b100100: r_alu = ALU_AND;
         6'b100101: r_alu = ALU_OR;
         6'b101010: r_alu = ALU_SLT;
         6'b100111: r_alu = ALU_NOR;
         default:   r_known = 1'b0;
      endcase
   end

   always_comb begin
      case (opcode)
         OP_ANDI: i_alu = ALU_AND;
         OP_ORI:  i_alu = ALU_OR;
         OP_SLTI: i_alu = ALU_SLT;
         default: i_alu = ALU_ADD;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      pc_ce_raw  = 1'b0;
      ior_d      = 1'b0;
      mem_rd_raw = 1'b0;
      mem_wr_raw = 1'b0;
      ir_we_raw  = 1'b0;
      reg_we_raw = 1'b0;
      reg_dst    = 2'b00;
      mem_to_reg = 2'b00;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      imm_zext   = 1'b0;
      alu_ctrl   = ALU_ADD;
      pc_src     = 2'b00;
      case (state_q)
         S_IF: begin
            mem_rd_raw = 1'b1;
            alu_src_b  = 2'b01;
            if (mem_ready) begin
               ir_we_raw = 1'b1;
               pc_ce_raw = 1'b1;
               state_d   = S_ID;
            end
         end
         S_ID: begin
            alu_src_b = 2'b11;
            case (opcode)
               OP_LW, OP_SW:                    state_d = S_MA;
               OP_R: begin
                  if (funct == FN_JR)           state_d = S_JR;
                  else if (r_known)             state_d = S_EXR;
                  else                          state_d = S_ILL;
               end
               OP_BEQ, OP_BNE:                  state_d = S_BR;
               OP_J:                            state_d = S_J;
               OP_JAL:                          state_d = S_JAL;
               OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_EXI;
               default:                         state_d = S_ILL;
            endcase
         end
         S_MA: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_d   = (opcode == OP_SW) ? S_MWR : S_MRD;
         end
         S_MRD: begin
            ior_d      = 1'b1;
            mem_rd_raw = 1'b1;
            if (mem_ready) state_d = S_LWB;
         end
         S_LWB: begin
            reg_we_raw = 1'b1;
            mem_to_reg = 2'b01;
            state_d    = S_IF;
         end
         S_MWR: begin
            ior_d      = 1'b1;
            mem_wr_raw = 1'b1;
            if (mem_ready) state_d = S_IF;
         end
         S_EXR: begin
            alu_src_a = 1'b1;
            alu_ctrl  = r_alu;
            state_d   = S_RWB;
         end
         S_RWB: begin
            reg_we_raw = 1'b1;
            reg_dst    = 2'b01;
            state_d    = S_IF;
         end
         S_BR: begin
            alu_src_a = 1'b1;
            alu_ctrl  = ALU_SUB;
            pc_src    = 2'b01;
            pc_ce_raw = ((opcode == OP_BEQ) & zero) | ((opcode == OP_BNE) & ~zero);
            state_d   = S_IF;
         end
         S_J: begin
            pc_src    = 2'b10;
            pc_ce_raw = 1'b1;
            state_d   = S_IF;
         end
         S_JAL: begin
            // PC still holds PC+4 this cycle, so $31 gets the link address
            pc_src     = 2'b10;
            pc_ce_raw  = 1'b1;
            reg_we_raw = 1'b1;
            reg_dst    = 2'b10;
            mem_to_reg = 2'b10;
            state_d    = S_IF;
         end
         S_EXI: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_ctrl  = i_alu;
            imm_zext  = (opcode == OP_ANDI) | (opcode == OP_ORI);
            state_d   = S_IWB;
         end
         S_IWB: begin
            reg_we_raw = 1'b1;
            state_d    = S_IF;
         end
         S_JR: begin
            pc_src    = 2'b11;
            pc_ce_raw = 1'b1;
            state_d   = S_IF;
         end
         default: state_d = S_IF;
      endcase
   end

   // Reset aborts any instruction in flight: no write escapes while rst is high
   assign pc_ce  = pc_ce_raw  & ~rst;
   assign mem_rd = mem_rd_raw & ~rst;
   assign mem_wr = mem_wr_raw & ~rst;
   assign ir_we  = ir_we_raw  & ~rst;
   assign reg_we = reg_we_raw & ~rst;
   assign state  = state_q;

endmodule

// File: doc/mc_ctrl_unit.md
Name: mc_ctrl_unit

Overview:
Multi-cycle MIPS control FSM that sequences the shared datapath: PC register, IR, register file, ALU and the single memory port. It drives the PC register's clock enable (`pc_ce`) and every mux select and write strobe. Memory accesses stall on `mem_ready`. It sits beside the datapath in the Exp CPU top level and decodes `opcode`/`funct` from the IR.

Parameters:
- ST_W, 4, state register width (encodings below are fixed).

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `mem_ready`  in  1  memory completes the current read/write this cycle.
- `opcode`  in  6  IR[31:26].
- `funct`  in  6  IR[5:0].
- `zero`  in  1  ALU zero flag (combinational, current ALU operands).
- `pc_ce`  out  1  PC register clock enable.
- `ior_d`  out  1  memory address: 0 = PC, 1 = ALUOut.
- `mem_rd`  out  1  memory read strobe.
- `mem_wr`  out  1  memory write strobe.
- `ir_we`  out  1  IR load.
- `reg_we`  out  1  register-file write.
- `reg_dst`  out  2  write address: 00 = rt, 01 = rd, 10 = $31.
- `mem_to_reg`  out  2  write data: 00 = ALUOut, 01 = MDR, 10 = PC.
- `alu_src_a`  out  1  0 = PC, 1 = rs.
- `alu_src_b`  out  2  00 = rt, 01 = 4, 10 = ext(imm), 11 = sext(imm)<<2.
- `imm_zext`  out  1  1 = zero-extend imm, 0 = sign-extend.
- `alu_ctrl`  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt, 100 nor.
- `pc_src`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = rs.
- `state`  out  4  current state, for debug.

Behaviour:
- State register: async reset to IF (0). All outputs are combinational decode of state, opcode, funct, `zero` and `mem_ready`.
- Output defaults: 0, with `alu_ctrl` = 010.
- While `rst` = 1, force `pc_ce`, `ir_we`, `reg_we`, `mem_rd` and `mem_wr` to 0. A reset mid-instruction aborts it with no further writes.
- Opcodes:
  - R = 000000, lw = 100011, sw = 101011
  - beq = 000100, bne = 000101, j = 000010, jal = 000011
  - addi = 001000, andi = 001100, ori = 001101, slti = 001010
- R-type funct → `alu_ctrl`: 100000 → 010, 100010 → 110, 100100 → 000, 100101 → 001, 101010 → 111, 100111 → 100. jr = 001000.
- States and transitions:
  - IF (0): `mem_rd`, `ior_d` = 0, `alu_src_a` = 0, `alu_src_b` = 01, add, `pc_src` = 00. If `mem_ready`: `ir_we` = `pc_ce` = 1 and go to ID; else hold with no strobes except `mem_rd`.
  - ID (1): `alu_src_a` = 0, `alu_src_b` = 11, add (branch target → ALUOut). Next state:
    - lw/sw → MA
    - R with jr → JR; R with a listed funct → EXR; R with any other funct → ILL
    - beq/bne → BR
    - j → J
    - jal → JAL
    - addi/andi/ori/slti → EXI
    - any other opcode → ILL
  - MA (2): `alu_src_a` = 1, `alu_src_b` = 10, add. Next: lw → MRD, sw → MWR.
  - MRD (3): `ior_d` = 1, `mem_rd` = 1. Wait for `mem_ready`, then → LWB.
  - LWB (4): `reg_we`, `reg_dst` = 00, `mem_to_reg` = 01. → IF.
  - MWR (5): `ior_d` = 1, `mem_wr` = 1. Wait for `mem_ready`, then → IF. `mem_wr` stays high throughout the wait.
  - EXR (6): `alu_src_a` = 1, `alu_src_b` = 00, `alu_ctrl` from funct. → RWB.
  - RWB (7): `reg_we`, `reg_dst` = 01, `mem_to_reg` = 00. → IF.
  - BR (8): `alu_src_a` = 1, `alu_src_b` = 00, sub, `pc_src` = 01. `pc_ce` = `zero` for beq, `~zero` for bne. → IF.
  - J (9): `pc_src` = 10, `pc_ce` = 1. → IF.
  - JAL (10): `pc_src` = 10, `pc_ce` = 1, `reg_we`, `reg_dst` = 10, `mem_to_reg` = 10. PC still holds PC+4 in this cycle, so $31 receives PC+4. → IF.
  - EXI (11): `alu_src_a` = 1, `alu_src_b` = 10. `alu_ctrl`: addi 010, andi 000, ori 001, slti 111. `imm_zext` = 1 for andi/ori only. → IWB.
  - IWB (12): `reg_we`, `reg_dst` = 00, `mem_to_reg` = 00. → IF.
  - JR (13): `pc_src` = 11, `pc_ce` = 1. → IF.
  - ILL (14): no writes, acts as NOP. → IF.
  - Encoding 15: unreachable; → IF with no writes.
- Cycles per instruction with `mem_ready` tied to 1:
  - R / I-ALU: 4
  - lw: 5
  - sw: 4
  - beq/bne/j/jal/jr: 3
  - ILL: 3
- Each wait cycle on `mem_ready` adds exactly 1 cycle.
- Exactly one `pc_ce` pulse per instruction in IF, plus at most one more in BR/J/JAL/JR.

Test Plan:
- `rst` = 1 for 2 cycles, then 0, `mem_ready` = 1, IR = add (op 000000, funct 100000) → states 0,1,6,7,0; `ir_we`/`pc_ce` pulse in cycle 0; `reg_we` = 1, `reg_dst` = 01 in cycle 3; `alu_ctrl` = 010 in EXR.
- lw with `mem_ready` low 2 cycles in MRD → states 0,1,2,3,3,3,4,0; `ior_d` = `mem_rd` = 1 throughout MRD; `reg_we` only in LWB, with `mem_to_reg` = 01.
- beq with `zero` = 1 → `pc_ce` = 1, `pc_src` = 01 in BR. Repeat with `zero` = 0 → `pc_ce` = 0. bne with `zero` = 0 → `pc_ce` = 1.
- jal → state 10 with `pc_ce` = 1, `pc_src` = 10, `reg_dst` = 10, `mem_to_reg` = 10, `reg_we` = 1. Then jr (funct 001000) → state 13 with `pc_src` = 11.
- ori → EXI shows `imm_zext` = 1, `alu_ctrl` = 001. Opcode 111111 → ID→ILL→IF with no write strobes.
- sw with `mem_ready` = 0, then assert `rst` mid-MWR → `mem_wr` drops to 0 the same cycle and `state` = 0 asynchronously. After release, IF waits for `mem_ready`.
